serial_pattern_tx: RTL and testbench

Serial bit-stream transmitter that produces the single-bit x_in stream consumed by the lab sequence-detector FSMs.
- Accepts a parallel WIDTH-bit word through a load/ready handshake.
- Shifts the word out MSB-first, one bit per clock.
- Optionally appends an even-parity bit, then holds the line low for a programmable inter-frame gap.
- Used as the stimulus end of the detector labs and in the lab top level.

---
 rtl/serial_tx_pkg.sv | 21 ++
 rtl/tx_down_counter.sv | 34 +++
 rtl/serial_pattern_tx.sv | 146 ++++++++++++++
 tb/tb_serial_pattern_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and sizing helpers for the serial pattern transmitter.
// The even-parity bit is compiled in only when SERIAL_TX_PARITY_EN is defined.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SHIFT  = 2'b01,
    S_PARITY = 2'b10,
    S_GAP    = 2'b11
  } state_t;

  // One counter serves both the bit count (max WIDTH-1) and the gap count
  // (max GAP_CYCLES-1); it is kept at least one bit wide.
  function automatic int cnt_width(input int width, input int gap);
    int m;
    m = (width > gap) ? width : gap;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/tx_down_counter.sv
// Loadable down-counter with a zero flag, used for both bit and gap counting.
module tx_down_counter #(
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// MSB-first serial transmitter with inter-frame low gap; optional even parity
// bit appended after the data when SERIAL_TX_PARITY_EN is defined.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             x_out,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int            CW       = cnt_width(WIDTH, GAP_CYCLES);
  localparam bit            HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  // Handshake: a word is taken on any rising edge where load && ready; ready
  // is high exactly while idle, and neither load nor data_in matter otherwise.

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              x_out_q, x_out_d;
  logic              done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic              cnt_load;
  logic [CW-1:0]     cnt_load_value;
  logic              cnt_dec;
  logic              cnt_zero;

  tx_down_counter #(.CW(CW)) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    x_out_d        = 1'b0;
    done_d         = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = BIT_LOAD;
    cnt_dec        = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d       = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d  = data_in;
          x_out_d  = data_in[WIDTH-1];
          cnt_load = 1'b1;
          state_d  = S_SHIFT;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      S_SHIFT: begin
        if (!cnt_zero) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          x_out_d = shift_q[WIDTH-2];
          cnt_dec = 1'b1;
        end else begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = S_PARITY;
          x_out_d = parity_q;
`else
          done_d = 1'b1;
          if (HAS_GAP) begin
            state_d        = S_GAP;
            cnt_load       = 1'b1;
            cnt_load_value = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
`endif
        end
      end
      S_PARITY: begin
`ifdef SERIAL_TX_PARITY_EN
        done_d = 1'b1;
        if (HAS_GAP) begin
          state_d        = S_GAP;
          cnt_load       = 1'b1;
          cnt_load_value = GAP_LOAD;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_GAP: begin
        // Entered with GAP_CYCLES-1 loaded, so the line stays low GAP_CYCLES cycles.
        if (cnt_zero) begin
          state_d = S_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      x_out_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      x_out_q  <= x_out_d;
      done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign x_out     = x_out_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: one instance with GAP_CYCLES=2, one with
// GAP_CYCLES=0; expected {x_out, done, ready} per active cycle are queued.
module tb_serial_pattern_tx;
  import serial_tx_pkg::*;

  logic       clock;
  logic       reset;
  logic [7:0] data_in0, data_in1;
  logic       load0, load1;
  logic       ready0, busy0, x_out0, done0;
  logic       ready1, busy1, x_out1, done1;
  logic [1:0] dbg_state0, dbg_state1;

  logic [2:0] exp_q0[$];
  logic [2:0] exp_q1[$];
  int         pass_cnt;
  int         total_cnt;

  serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(2)) dut0 (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in0),
    .load      (load0),
    .ready     (ready0),
    .busy      (busy0),
    .x_out     (x_out0),
    .done      (done0),
    .dbg_state (dbg_state0)
  );

  serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0)) dut1 (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in1),
    .load      (load1),
    .ready     (ready1),
    .busy      (busy1),
    .x_out     (x_out1),
    .done      (done1),
    .dbg_state (dbg_state1)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle output of one frame, MSB first, then parity, then gap/idle.
  task automatic push_frame(input int which, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      if (which == 0) exp_q0.push_back({w[i], 2'b00});
      else            exp_q1.push_back({w[i], 2'b00});
    end
`ifdef SERIAL_TX_PARITY_EN
    if (which == 0) exp_q0.push_back({^w, 2'b00});
    else            exp_q1.push_back({^w, 2'b00});
`endif
    if (which == 0) begin
      exp_q0.push_back(3'b010);
      exp_q0.push_back(3'b000);
    end else begin
      exp_q1.push_back(3'b011);
    end
  endtask

  // driver tasks
  task automatic send0(input logic [7:0] w);
    int n;
    n = 0;
    while (!ready0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check("send0_ready", {31'd0, ready0}, 32'd1);
    data_in0 = w;
    load0    = 1'b1;
    @(posedge clock);
    push_frame(0, w);
    #1 load0 = 1'b0;
  endtask

  task automatic wait_end0(input string name);
    int n;
    n = 0;
    while (!ready0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_ready"}, {31'd0, ready0}, 32'd1);
    @(negedge clock); #1;
    check({name, "_q_empty"}, exp_q0.size(), 32'd0);
  endtask

  // scoreboard monitors
  always @(negedge clock) begin
    if (reset && (busy0 || done0)) begin
      if (exp_q0.size() == 0) begin
        check("dut0_unexpected_out", {29'd0, x_out0, done0, ready0}, 32'hffff_ffff);
      end else begin
        check("dut0_out", {29'd0, x_out0, done0, ready0}, {29'd0, exp_q0.pop_front()});
      end
    end
  end

  always @(negedge clock) begin
    if (reset && (busy1 || done1)) begin
      if (exp_q1.size() == 0) begin
        check("dut1_unexpected_out", {29'd0, x_out1, done1, ready1}, 32'hffff_ffff);
      end else begin
        check("dut1_out", {29'd0, x_out1, done1, ready1}, {29'd0, exp_q1.pop_front()});
      end
    end
  end

  // stimulus
  initial begin
    int n;
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b0;
    data_in0  = 8'h00;
    data_in1  = 8'h00;
    load0     = 1'b0;
    load1     = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_x_out", {31'd0, x_out0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_ready", {31'd0, ready0}, 32'd1);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_state", {30'd0, dbg_state0}, {30'd0, S_IDLE});
    reset = 1'b1;
    @(posedge clock); #1;

    // basic A5 frame, ready must be back in cycle WIDTH(+parity)+GAP+1
    send0(8'hA5);
`ifdef SERIAL_TX_PARITY_EN
    repeat (11) @(posedge clock);
`else
    repeat (10) @(posedge clock);
`endif
    #1;
    check("t1_ready_after_frame", {31'd0, ready0}, 32'd1);
    @(negedge clock); #1;
    check("t1_q_empty", exp_q0.size(), 32'd0);

    // load pulse with FF in cycle 3 must be ignored
    send0(8'hA5);
    repeat (2) @(posedge clock);
    #1;
    data_in0 = 8'hFF;
    load0    = 1'b1;
    @(posedge clock); #1;
    load0    = 1'b0;
    wait_end0("t2");

    // reset in cycle 4 of an F0 frame, then a clean 3C frame
    send0(8'hF0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("t3_rst_x_out", {31'd0, x_out0}, 32'd0);
    check("t3_rst_busy", {31'd0, busy0}, 32'd0);
    check("t3_rst_ready", {31'd0, ready0}, 32'd1);
    check("t3_rst_done", {31'd0, done0}, 32'd0);
    exp_q0.delete();
    #3 reset = 1'b1;
    @(posedge clock); #1;
    send0(8'h3C);
    wait_end0("t3");

`ifdef SERIAL_TX_PARITY_EN
    send0(8'h07);
    wait_end0("t5a");
    send0(8'h03);
    wait_end0("t5b");
`endif

    // GAP_CYCLES=0 instance with load held high: 81 then 7E back to back
    @(posedge clock); #1;
    data_in1 = 8'h81;
    load1    = 1'b1;
    @(posedge clock);
    push_frame(1, 8'h81);
    #1 data_in1 = 8'h7E;
    n = 0;
    while (!ready1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("t4_ready_between", {31'd0, ready1}, 32'd1);
    check("t4_done_with_ready", {31'd0, done1}, 32'd1);
    @(posedge clock);
    push_frame(1, 8'h7E);
    #1 load1 = 1'b0;
    n = 0;
    while (!ready1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("t4_ready_end", {31'd0, ready1}, 32'd1);
    @(negedge clock); #1;
    check("t4_q_empty", exp_q1.size(), 32'd0);

    repeat (4) @(posedge clock);
    #1;
    check("final_q0_empty", exp_q0.size(), 32'd0);
    check("final_idle0", {31'd0, ready0}, 32'd1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
